serial_arith_unit: RTL and testbench
====================================

// Module: serial_arith_unit
// PURPOSE
//  Parametrised multi-cycle arithmetic/logic unit built from full-adder / full-subtractor cells.
//  Processes DIGIT bits per cycle, LSB first, over WIDTH/DIGIT cycles.
//  Supports ADD, SUB and six two-input logic ops on WIDTH-bit operands.
//  Sits between operand producers and result consumers behind valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >=2; WIDTH % DIGIT == 0
//  DIGIT  2  bits processed per cycle (ripple chain length); 1..WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-high reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      unit can accept an operation
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   3      operation select (see BEHAVIOUR)
//  cin        in   1      carry-in (ADD) / borrow-in (SUB); ignored for logic ops
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  cout       out  1      carry-out (ADD) / borrow-out (SUB); 0 for logic ops
// BEHAVIOUR
//  op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 NAND, 111 NOR.
//  ADD: {cout,result} = a + b + cin.
//  SUB: result = a - b - cin mod 2^WIDTH; cout = 1 iff a < b + cin (unsigned).
//  Reset (async): state=IDLE; in_ready=0 while rst high; out_valid=0; result=0; cout=0; digit counter=0.
//  States:
//   IDLE
//    - in_ready=1.
//    - Accept on in_valid&&in_ready: latch a, b, op; carry=cin; cnt=0 -> RUN.
//   RUN
//    - in_ready=0.
//    - Each cycle processes bits [cnt*DIGIT +: DIGIT] through DIGIT chained cells.
//    - Writes those result bits and updates the carry/borrow register; cnt++.
//    - At cnt==WIDTH/DIGIT-1 -> DONE, with the final digit written on that edge.
//   DONE
//    - out_valid=1; result/cout stable.
//    - On out_valid&&out_ready -> IDLE; out_valid drops on that edge.
//  Timing:
//   - Latency: accept at edge k gives out_valid=1 after edge k+WIDTH/DIGIT.
//   - Minimum issue interval: WIDTH/DIGIT+2 cycles (accept, RUN cycles, DONE, back to IDLE).
//   - in_ready is low in RUN and DONE; in_valid and operand changes are ignored there.
//     Operands are sampled only at the accept edge.
//  Backpressure: DONE holds indefinitely while out_ready=0; result/cout/out_valid do not change.
//  Logic ops: cout=0; the carry register is unused.
//  Corner cases:
//   - DIGIT==WIDTH: single RUN cycle.
//   - DIGIT==1: fully bit-serial.
//  Reset mid-operation: aborts immediately; no out_valid is produced; partial result discarded.
//   Normal accept resumes on the first edge after rst deasserts.
//  out_ready while not DONE has no effect.
// CONFIGURATION
//  ALU_FLAGS_EN defined:
//   - Adds outputs zero (1), neg (1) and ovf (1), registered and updated together with result.
//   - zero = (result==0).
//   - neg = result[WIDTH-1].
//   - ovf = signed two's-complement overflow for ADD/SUB (operand signs vs result sign), 0 for logic.
//   - Flags reset to 0 and hold in DONE.
//  ALU_FLAGS_EN undefined: the ports zero/neg/ovf are absent; no other behaviour changes.
// TESTING (WIDTH=8, DIGIT=2 unless noted)
//  1. ADD a=0xFF b=0x01 cin=0, out_ready=1 -> result=0x00, cout=1.
//     out_valid rises exactly 4 edges after accept.
//  2. SUB a=0x05 b=0x07 cin=0 -> result=0xFE, cout=1.
//     SUB a=0x07 b=0x05 cin=1 -> result=0x01, cout=0.
//  3. XNOR a=0xA5 b=0x0F -> result=0x55, cout=0.
//     Repeat with DIGIT=1 (8-edge latency) and DIGIT=8 (1-edge latency).
//  4. Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands:
//     -> result/cout/out_valid stable, in_ready=0, no new accept.
//     Then out_ready=1 -> IDLE next edge.
//  5. Assert rst during the 2nd RUN cycle of an ADD:
//     -> out_valid never rises, all outputs 0.
//     A following ADD 0x12+0x34 gives 0x46.
//  6. With ALU_FLAGS_EN: ADD 0x7F+0x01 -> result=0x80, ovf=1, neg=1, zero=0.
//     SUB 0x10-0x10 -> zero=1, ovf=0.

Source files
------------

// File: rtl/serial_arith_unit.sv
// Digit-serial ALU: ADD/SUB through a DIGIT-long full-adder/full-subtractor ripple chain, plus six logic ops.
// Optional flag outputs zero/neg/ovf are compiled in when ALU_FLAGS_EN is defined.
module serial_arith_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int IW   = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_op;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_arith;
  logic [IW-1:0]    w_base;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_dig;
  logic             w_c;
  logic [WIDTH-1:0] w_res_full;
  logic             w_ovf;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE (and low during reset), out_valid is high only in DONE.
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && (r_state == S_IDLE) && !rst;
  assign w_last    = (r_cnt == CW'(NDIG - 1));
  assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_base    = IW'(r_cnt * DIGIT);
  assign w_a_dig   = r_a[w_base +: DIGIT];
  assign w_b_dig   = r_b[w_base +: DIGIT];
  assign result    = r_result;
  assign cout      = r_cout;
  assign dbg_state = r_state;

  // One digit of cells; w_c ripples from r_carry through each bit position.
  always_comb begin
    w_c   = r_carry;
    w_dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      case (r_op)
        OP_ADD: begin
          w_dig[i] = w_a_dig[i] ^ w_b_dig[i] ^ w_c;
          w_c      = (w_a_dig[i] & w_b_dig[i]) | (w_c & (w_a_dig[i] ^ w_b_dig[i]));
        end
        OP_SUB: begin
          w_dig[i] = w_a_dig[i] ^ w_b_dig[i] ^ w_c;
          w_c      = (~w_a_dig[i] & w_b_dig[i]) | (~(w_a_dig[i] ^ w_b_dig[i]) & w_c);
        end
        OP_AND:  w_dig[i] = w_a_dig[i] & w_b_dig[i];
        OP_OR:   w_dig[i] = w_a_dig[i] | w_b_dig[i];
        OP_XOR:  w_dig[i] = w_a_dig[i] ^ w_b_dig[i];
        OP_XNOR: w_dig[i] = ~(w_a_dig[i] ^ w_b_dig[i]);
        OP_NAND: w_dig[i] = ~(w_a_dig[i] & w_b_dig[i]);
        default: w_dig[i] = ~(w_a_dig[i] | w_b_dig[i]);
      endcase
    end
  end

  always_comb begin
    w_res_full                   = r_result;
    w_res_full[w_base +: DIGIT]  = w_dig;
  end

  // Signed overflow judged on the full result as it will look after the final digit.
  always_comb begin
    w_ovf = 1'b0;
    if (r_op == OP_ADD)
      w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res_full[WIDTH-1] != r_a[WIDTH-1]);
    else if (r_op == OP_SUB)
      w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res_full[WIDTH-1] != r_a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic r_zero;
  logic r_neg;
  logic r_ovf;
  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_zero <= (w_res_full == '0);
      r_neg  <= w_res_full[WIDTH-1];
      r_ovf  <= w_ovf;
    end
  end
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_result <= w_res_full;
          r_carry  <= w_c;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) r_cout <= w_arith ? w_c : 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed bench for serial_arith_unit: three instances (DIGIT=2, 1, 8) sharing operand buses.
module tb_serial_arith_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       cin = 1'b0;
  logic       out_ready = 1'b1;
  logic       iv2 = 1'b0, iv1 = 1'b0, iv8 = 1'b0;

  logic       ir2, ir1, ir8, ov2, ov1, ov8, co2, co1, co8;
  logic [7:0] res2, res1, res8;
  logic [1:0] st2, st1, st8;
`ifdef ALU_FLAGS_EN
  logic       z2, n2, f2, z1, n1, f1, z8, n8, f8;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_arith_unit #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(ov2), .out_ready(out_ready), .result(res2), .cout(co2),
`ifdef ALU_FLAGS_EN
    .zero(z2), .neg(n2), .ovf(f2),
`endif
    .dbg_state(st2));

  serial_arith_unit #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .cout(co1),
`ifdef ALU_FLAGS_EN
    .zero(z1), .neg(n1), .ovf(f1),
`endif
    .dbg_state(st1));

  serial_arith_unit #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(ov8), .out_ready(out_ready), .result(res8), .cout(co8),
`ifdef ALU_FLAGS_EN
    .zero(z8), .neg(n8), .ovf(f8),
`endif
    .dbg_state(st8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ov_of(input int sel);
    case (sel)
      1: return ov1;
      8: return ov8;
      default: return ov2;
    endcase
  endfunction

  function automatic logic ir_of(input int sel);
    case (sel)
      1: return ir1;
      8: return ir8;
      default: return ir2;
    endcase
  endfunction

  function automatic logic co_of(input int sel);
    case (sel)
      1: return co1;
      8: return co8;
      default: return co2;
    endcase
  endfunction

  function automatic logic [7:0] res_of(input int sel);
    case (sel)
      1: return res1;
      8: return res8;
      default: return res2;
    endcase
  endfunction

  function automatic logic [1:0] st_of(input int sel);
    case (sel)
      1: return st1;
      8: return st8;
      default: return st2;
    endcase
  endfunction

  task automatic set_iv(input int sel, input logic v);
    case (sel)
      1: iv1 = v;
      8: iv8 = v;
      default: iv2 = v;
    endcase
  endtask

  // Drive one operation at the falling edge; accept happens on the next rising edge.
  task automatic issue(input int sel, input string tag, input logic [2:0] o,
                       input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; op = o; cin = c;
    set_iv(sel, 1'b1);
    check({tag, "_ready"}, ir_of(sel), 1);
    @(posedge clk);
    #1;
    set_iv(sel, 1'b0);
    check({tag, "_run"}, st_of(sel), 1);
  endtask

  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (!ov_of(sel) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input int sel, input string tag, input logic [2:0] o,
                        input logic [7:0] x, input logic [7:0] y, input logic c,
                        input logic [7:0] exp_r, input logic exp_c, input int exp_lat);
    int   lat;
    logic exp_ovf;
    exp_q.push_back(exp_r);
    issue(sel, tag, o, x, y, c);
    wait_done(sel, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, res_of(sel), exp_q.pop_front());
    check({tag, "_cout"}, co_of(sel), exp_c);
    exp_ovf = (o == 3'b000) ? ((x[7] == y[7]) && (exp_r[7] != x[7])) :
              (o == 3'b001) ? ((x[7] != y[7]) && (exp_r[7] != x[7])) : 1'b0;
`ifdef ALU_FLAGS_EN
    if (sel == 2) begin
      check({tag, "_zero"}, z2, (exp_r == 8'h00));
      check({tag, "_neg"}, n2, exp_r[7]);
      check({tag, "_ovf"}, f2, exp_ovf);
    end
`else
    if (exp_ovf && sel == 0) $display("note: unreachable");
`endif
    @(posedge clk);
    #1;
    check({tag, "_drop"}, ov_of(sel), 0);
    check({tag, "_idle"}, ir_of(sel), 1);
  endtask

  initial begin
    int lat;
    int ov_seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ir2, 0);
    check("rst_valid", ov2, 0);
    check("rst_res", res2, 8'h00);
    check("rst_cout", co2, 0);
    check("rst_state", st2, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", ir2, 1);

    run_op(2, "add_ff_01", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4);
    run_op(2, "add_cin",   3'b000, 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 4);
    run_op(2, "sub_5_7",   3'b001, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 4);
    run_op(2, "sub_7_5_b", 3'b001, 8'h07, 8'h05, 1'b1, 8'h01, 1'b0, 4);
    run_op(2, "sub_0_0_b", 3'b001, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 4);
    run_op(2, "and",       3'b010, 8'hA5, 8'h0F, 1'b1, 8'h05, 1'b0, 4);
    run_op(2, "or",        3'b011, 8'hA5, 8'h0F, 1'b0, 8'hAF, 1'b0, 4);
    run_op(2, "xor",       3'b100, 8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0, 4);
    run_op(2, "xnor",      3'b101, 8'hA5, 8'h0F, 1'b0, 8'h55, 1'b0, 4);
    run_op(2, "nand",      3'b110, 8'hA5, 8'h0F, 1'b1, 8'hFA, 1'b0, 4);
    run_op(2, "nor",       3'b111, 8'hA5, 8'h0F, 1'b0, 8'h50, 1'b0, 4);
    run_op(1, "xnor_d1",   3'b101, 8'hA5, 8'h0F, 1'b0, 8'h55, 1'b0, 8);
    run_op(8, "xnor_d8",   3'b101, 8'hA5, 8'h0F, 1'b0, 8'h55, 1'b0, 1);
    run_op(1, "add_d1",    3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8);
    run_op(8, "sub_d8",    3'b001, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1);
    run_op(2, "add_7f_01", 3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 4);
    run_op(2, "sub_10_10", 3'b001, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 4);

    // Backpressure: DONE must hold while out_ready is low, ignoring new requests.
    out_ready = 1'b0;
    issue(2, "bp", 3'b000, 8'h0F, 8'h01, 1'b1);
    wait_done(2, lat);
    check("bp_lat", lat, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      op = 3'($urandom_range(0, 7));
      iv2 = 1'b1;
      @(posedge clk);
      #1;
      check("bp_res", res2, 8'h11);
      check("bp_cout", co2, 0);
      check("bp_valid", ov2, 1);
      check("bp_ready", ir2, 0);
    end
    @(negedge clk);
    iv2 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", ov2, 0);
    check("bp_release_ready", ir2, 1);
    check("bp_release_res", res2, 8'h11);
    @(posedge clk);
    #1;
    check("bp_no_accept", st2, 0);

    // Reset during the second RUN cycle discards the operation.
    issue(2, "rst_mid", 3'b000, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", ov2, 0);
    check("rst_mid_res", res2, 8'h00);
    check("rst_mid_cout", co2, 0);
    check("rst_mid_ready", ir2, 0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ov2) ov_seen++;
    end
    check("rst_mid_no_valid", ov_seen, 0);
    check("rst_mid_idle", st2, 0);
    run_op(2, "add_12_34", 3'b000, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "bench timed out");
  end

endmodule
